scan_key_accum: RTL and testbench
=================================

# scan_key_accum

Parametrised successor to the combinational scan-code digit decoder. Consumes the registered PS/2 byte stream (one byte per `scan_valid` strobe) and tracks break (F0) and extended (E0) prefixes in a state machine. Emits one key event per make code and accumulates keypad digits into a BCD operand. The operand is released to the calculator ALU front-end when an operator key is pressed.

## Interface
- `DIGITS`, default 4: maximum BCD digits held in the operand (1..8).
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `scan_code` in 8: received PS/2 byte, valid only with `scan_valid`.
- `scan_valid` in 1: single-cycle byte strobe; no backpressure.
- `key_code` out 6: decoded code of the last key event.
- `key_valid` out 1: single-cycle strobe, make events only.
- `op_valid` out 1: single-cycle strobe on an operator make.
- `op_code` out 3: operator, 0:+ 1:- 2:* 3:/ 4:Enter.
- `op_operand` out 4*DIGITS: BCD operand latched at `op_valid`.
- `operand` out 4*DIGITS: live BCD accumulator, LS digit in [3:0].
- `digit_count` out $clog2(DIGITS+1): number of digits held.
- `overflow` out 1: sticky; a digit was dropped because the accumulator was full.

## Operation
- Key codes:
  - Keypad digits 70,69,72,7A,6B,73,74,6C,75,7D map to 0..9.
  - Operators: 79 -> 6'b010_000 (+), 7B -> 010_001 (-), 7C -> 010_010 (*), E0 4A -> 010_011 (/), E0 5A -> 010_100 (Enter).
  - 66 (Backspace) -> 010_101; 76 (Esc) -> 010_110.
  - Any other make -> 6'b110_000 (unknown). It still pulses `key_valid` and has no other effect.
- FSM states:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is decoded as a make.
  - EXT: F0 -> EXT_BRK; other byte is decoded as an extended make -> IDLE.
  - BRK, EXT_BRK: the next byte is consumed silently -> IDLE. No event is emitted.
- Digit make:
  - `digit_count` < DIGITS: `operand` = {operand[4*DIGITS-5:0], d}; count +1.
  - `digit_count` == DIGITS: digit dropped, `overflow` set.
  - Digit 0 with count 0 is ignored (no leading zeros).
- Backspace: `operand` shifts right one digit, zero-filled; count -1, saturating at 0; `overflow` cleared.
- Esc: `operand`, `digit_count` and `overflow` cleared.
- Operator make:
  - `op_valid`=1, `op_code` set, `op_operand` loaded with the current `operand`.
  - Accumulator, count and overflow cleared on the same edge.
- Reset values: all outputs 0; FSM in IDLE. A reset mid-sequence (e.g. after E0) discards the prefix.

## Timing
- One byte is processed per `scan_valid` cycle; back-to-back strobes are legal in every state.
- `key_valid`, `op_valid`, `key_code`, `op_code` and `op_operand` are registered and appear exactly 1 cycle after the `scan_valid` edge of the final byte.
- `operand` and `digit_count` update on that same edge. They are therefore coincident with `key_valid`.
- Prefix bytes (E0, F0) and break bytes never raise `key_valid`.
- `key_code` and `op_code` hold their values until the next event. `op_operand` holds until the next operator.
- If `scan_valid` is low, nothing changes except that strobes clear to 0.
- If `rst_n`=0 at the same edge as `scan_valid`, reset wins.

## Configuration
- `SCAN_EXT_KEYS_EN` defined:
  - The EXT and EXT_BRK states exist.
  - E0 4A decodes as `/` and E0 5A decodes as Enter.
- Undefined:
  - E0 is discarded silently in IDLE with no state change.
  - The following byte is decoded as a plain make, so E0 4A and E0 5A give unknown (110_000).
  - E0 F0 xx behaves as F0 xx.
  - `op_code` values 3 and 4 are never produced.

## Test plan
- Reset, then bytes 69,72,7A -> three `key_valid` pulses with codes 1,2,3; `operand`=16'h0123; `digit_count`=3.
- Bytes 69,F0,69 -> one `key_valid` only; `operand`=16'h0001.
- DIGITS=4, bytes 69,72,7A,6B,73 -> `operand`=16'h1234, `overflow`=1. Then 66 -> `operand`=16'h0123, `overflow`=0, count 3.
- Bytes 69,72,79 -> at the 79 event `op_valid`=1, `op_code`=0, `op_operand`=16'h0012. Same cycle: `operand`=0, `digit_count`=0.
- With `SCAN_EXT_KEYS_EN`, bytes 7D,E0,5A -> `op_code`=4, `op_operand`=16'h0009. Without the macro, the same bytes give `key_code`=6'b110_000 and no `op_valid`.
- Bytes 70,70,69,E0, then `rst_n` low 1 cycle, then 72 -> `operand`=16'h0002; `key_code`=2; no extended decode.

Source files
------------

// File: rtl/scan_key_accum_if.sv
// scan_key_accum_if: byte-stream input and key/operand result bundle for
// scan_key_accum. The slave modport is the decoder side; the master modport is
// whoever feeds PS/2 bytes and consumes the events.
interface scan_key_accum_if #(
    parameter int DIGITS = 4
);
    localparam int OPW = 4 * DIGITS;
    localparam int CW  = $clog2(DIGITS + 1);

    logic [7:0]     scan_code;
    logic           scan_valid;
    logic [5:0]     key_code;
    logic           key_valid;
    logic           op_valid;
    logic [2:0]     op_code;
    logic [OPW-1:0] op_operand;
    logic [OPW-1:0] operand;
    logic [CW-1:0]  digit_count;
    logic           overflow;

    modport master (
        output scan_code, scan_valid,
        input  key_code, key_valid, op_valid, op_code, op_operand,
               operand, digit_count, overflow
    );

    modport slave (
        input  scan_code, scan_valid,
        output key_code, key_valid, op_valid, op_code, op_operand,
               operand, digit_count, overflow
    );
endinterface

// File: rtl/scan_key_accum.sv
// scan_key_accum: PS/2 scan-byte decoder with break/extended prefix tracking,
// keypad BCD operand accumulator and operator release to the ALU front-end.
// Optional feature macro: SCAN_EXT_KEYS_EN enables the E0 prefix states so that
// E0 4A decodes as '/' and E0 5A as Enter. Without it E0 is dropped in IDLE and
// the following byte decodes as a plain make.
//
// state     | meaning
// IDLE      | waiting for a make code or a prefix byte
// BRK       | F0 seen; the next byte is the released key and is dropped
// EXT       | E0 seen; the next byte is an extended make (ext builds only)
// EXT_BRK   | E0 F0 seen; the next byte is dropped (ext builds only)
module scan_key_accum #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    scan_key_accum_if.slave  bus
);
    localparam int OPW = 4 * DIGITS;
    localparam int CW  = $clog2(DIGITS + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
`ifdef SCAN_EXT_KEYS_EN
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;
`endif

    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_EXT = 8'hE0;

    localparam logic [5:0] KC_ADD  = 6'b010_000;
    localparam logic [5:0] KC_SUB  = 6'b010_001;
    localparam logic [5:0] KC_MUL  = 6'b010_010;
`ifdef SCAN_EXT_KEYS_EN
    localparam logic [5:0] KC_DIV  = 6'b010_011;
    localparam logic [5:0] KC_ENT  = 6'b010_100;
`endif
    localparam logic [5:0] KC_BKSP = 6'b010_101;
    localparam logic [5:0] KC_ESC  = 6'b010_110;
    localparam logic [5:0] KC_UNK  = 6'b110_000;

    function automatic logic [5:0] decode_base(input logic [7:0] sc);
        case (sc)
            8'h70:   decode_base = 6'd0;
            8'h69:   decode_base = 6'd1;
            8'h72:   decode_base = 6'd2;
            8'h7A:   decode_base = 6'd3;
            8'h6B:   decode_base = 6'd4;
            8'h73:   decode_base = 6'd5;
            8'h74:   decode_base = 6'd6;
            8'h6C:   decode_base = 6'd7;
            8'h75:   decode_base = 6'd8;
            8'h7D:   decode_base = 6'd9;
            8'h79:   decode_base = KC_ADD;
            8'h7B:   decode_base = KC_SUB;
            8'h7C:   decode_base = KC_MUL;
            8'h66:   decode_base = KC_BKSP;
            8'h76:   decode_base = KC_ESC;
            default: decode_base = KC_UNK;
        endcase
    endfunction

`ifdef SCAN_EXT_KEYS_EN
    function automatic logic [5:0] decode_ext(input logic [7:0] sc);
        case (sc)
            8'h4A:   decode_ext = KC_DIV;
            8'h5A:   decode_ext = KC_ENT;
            default: decode_ext = KC_UNK;
        endcase
    endfunction
`endif

    logic [1:0]     r_state;
    logic [5:0]     r_key_code;
    logic           r_key_valid;
    logic           r_op_valid;
    logic [2:0]     r_op_code;
    logic [OPW-1:0] r_op_operand;
    logic [OPW-1:0] r_operand;
    logic [CW-1:0]  r_count;
    logic           r_overflow;

    logic [1:0]     w_state_nxt;
    logic           w_make;
    logic [5:0]     w_code;
    logic           w_is_digit;
    logic [3:0]     w_digit;
    logic           w_is_op;
    logic           w_full;
    logic           w_lead_zero;

    // Prefix tracking: pick the next state and decide whether this byte is a make.
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_code      = KC_UNK;
        if (bus.scan_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.scan_code == SC_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (bus.scan_code == SC_EXT) begin
`ifdef SCAN_EXT_KEYS_EN
                        w_state_nxt = ST_EXT;
`endif
                    end else begin
                        w_make = 1'b1;
                        w_code = decode_base(bus.scan_code);
                    end
                end
`ifdef SCAN_EXT_KEYS_EN
                ST_EXT: begin
                    if (bus.scan_code == SC_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_make      = 1'b1;
                        w_code      = decode_ext(bus.scan_code);
                    end
                end
`endif
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_is_digit  = (w_code[5:4] == 2'b00);
    assign w_digit     = w_code[3:0];
    assign w_is_op     = (w_code[5:3] == 3'b010) && (w_code[2:0] <= 3'd4);
    assign w_full      = (r_count == CW'(DIGITS));
    assign w_lead_zero = (w_digit == 4'd0) && (r_count == '0);

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key events, operand accumulation and operator release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_code   <= '0;
            r_key_valid  <= 1'b0;
            r_op_valid   <= 1'b0;
            r_op_code    <= '0;
            r_op_operand <= '0;
            r_operand    <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_key_valid <= w_make;
            r_op_valid  <= 1'b0;
            if (w_make) begin
                r_key_code <= w_code;
                if (w_is_digit) begin
                    if (!w_lead_zero) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_operand <= (r_operand << 4) | OPW'(w_digit);
                            r_count   <= r_count + CW'(1);
                        end
                    end
                end else if (w_is_op) begin
                    r_op_valid   <= 1'b1;
                    r_op_code    <= w_code[2:0];
                    r_op_operand <= r_operand;
                    r_operand    <= '0;
                    r_count      <= '0;
                    r_overflow   <= 1'b0;
                end else if (w_code == KC_BKSP) begin
                    r_operand  <= r_operand >> 4;
                    if (r_count != '0) begin
                        r_count <= r_count - CW'(1);
                    end
                    r_overflow <= 1'b0;
                end else if (w_code == KC_ESC) begin
                    r_operand  <= '0;
                    r_count    <= '0;
                    r_overflow <= 1'b0;
                end
            end
        end
    end

    assign bus.key_code    = r_key_code;
    assign bus.key_valid   = r_key_valid;
    assign bus.op_valid    = r_op_valid;
    assign bus.op_code     = r_op_code;
    assign bus.op_operand  = r_op_operand;
    assign bus.operand     = r_operand;
    assign bus.digit_count = r_count;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_scan_key_accum.sv
// tb_scan_key_accum: directed vector table, hand-written prefix/reset sequences
// and random byte streams, checked against a digit-queue reference model.
module tb_scan_key_accum;
    localparam int DIGITS = 4;
`ifdef SCAN_EXT_KEYS_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    scan_key_accum_if #(.DIGITS(DIGITS)) bus ();

    scan_key_accum #(.DIGITS(DIGITS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [7:0]  code;
        logic        kv;
        logic [5:0]  kc;
        logic        opv;
        logic [2:0]  opc;
        logic [15:0] opo;
        logic [15:0] opr;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [7:0]  digit_sc [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                   8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    bit          m_skip;
    bit          m_ext;
    int          m_dig[$];
    logic        m_kv;
    logic [5:0]  m_kc;
    logic        m_opv;
    logic [2:0]  m_opc;
    logic [15:0] m_opo;
    logic        m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_digits();
        logic [15:0] v;
        v = '0;
        foreach (m_dig[i]) v = (v << 4) | 16'(m_dig[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_skip = 0; m_ext = 0; m_dig.delete();
        m_kv = 0; m_kc = '0; m_opv = 0; m_opc = '0; m_opo = '0; m_ovf = 0;
    endtask

    task automatic model_make(input logic [7:0] b, input bit ext);
        int d;
        logic [5:0] kc;
        d = -1;
        if (ext) begin
            kc = (b == 8'h4A) ? 6'h13 : (b == 8'h5A) ? 6'h14 : 6'h30;
        end else begin
            for (int i = 0; i < 10; i++) if (digit_sc[i] == b) d = i;
            if (d >= 0)          kc = 6'(d);
            else if (b == 8'h79) kc = 6'h10;
            else if (b == 8'h7B) kc = 6'h11;
            else if (b == 8'h7C) kc = 6'h12;
            else if (b == 8'h66) kc = 6'h15;
            else if (b == 8'h76) kc = 6'h16;
            else                 kc = 6'h30;
        end
        m_kv = 1;
        m_kc = kc;
        if (d >= 0) begin
            if (!(d == 0 && m_dig.size() == 0)) begin
                if (m_dig.size() == DIGITS) m_ovf = 1;
                else m_dig.push_back(d);
            end
        end else if (kc >= 6'h10 && kc <= 6'h14) begin
            m_opv = 1;
            m_opc = kc[2:0];
            m_opo = pack_digits();
            m_dig.delete();
            m_ovf = 0;
        end else if (kc == 6'h15) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
            m_ovf = 0;
        end else if (kc == 6'h16) begin
            m_dig.delete();
            m_ovf = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_skip) begin
            m_skip = 0;
            m_ext  = 0;
        end else if (b == 8'hF0) begin
            m_skip = 1;
            m_ext  = 0;
        end else if (b == 8'hE0 && !m_ext) begin
            if (EXT_EN) m_ext = 1;
        end else begin
            model_make(b, m_ext);
            m_ext = 0;
        end
    endtask

    task automatic check_model();
        check("key_valid",   32'(bus.key_valid),   32'(m_kv));
        check("key_code",    32'(bus.key_code),    32'(m_kc));
        check("op_valid",    32'(bus.op_valid),    32'(m_opv));
        check("op_code",     32'(bus.op_code),     32'(m_opc));
        check("op_operand",  32'(bus.op_operand),  32'(m_opo));
        check("operand",     32'(bus.operand),     32'(pack_digits()));
        check("digit_count", 32'(bus.digit_count), 32'(m_dig.size()));
        check("overflow",    32'(bus.overflow),    32'(m_ovf));
    endtask

    // one clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic cycle(input bit rst, input bit vld, input logic [7:0] code);
        @(negedge clk);
        rst_n          = !rst;
        bus.scan_valid = vld;
        bus.scan_code  = code;
        @(posedge clk);
        #1;
        m_kv  = 0;
        m_opv = 0;
        if (rst) model_reset();
        else if (vld) model_byte(code);
        check_model();
    endtask

    task automatic add(input bit rst, input bit vld, input logic [7:0] code,
                       input logic kv, input logic [5:0] kc, input logic opv,
                       input logic [2:0] opc, input logic [15:0] opo,
                       input logic [15:0] opr, input logic [2:0] cnt, input logic ovf);
        vec_t v;
        v.rst = rst; v.vld = vld; v.code = code; v.kv = kv; v.kc = kc; v.opv = opv;
        v.opc = opc; v.opo = opo; v.opr = opr; v.cnt = cnt; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0]  opc_h;
        logic [15:0] opo_h;
        logic [7:0]  b;
        int          r;

        rst_n          = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        model_reset();

        //  rst vld code   kv kc     opv opc opo       opr       cnt ovf
        add(1, 0, 8'h00, 0, 6'h00, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 1, 8'h69, 1, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 8'h72, 1, 6'h02, 0, 0, 16'h0000, 16'h0012, 2, 0);
        add(0, 1, 8'h7A, 1, 6'h03, 0, 0, 16'h0000, 16'h0123, 3, 0);
        add(1, 0, 8'h00, 0, 6'h00, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 1, 8'h69, 1, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 8'hF0, 0, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 8'h69, 0, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 0, 8'h69, 0, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 8'h76, 1, 6'h16, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 1, 8'h69, 1, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 8'h72, 1, 6'h02, 0, 0, 16'h0000, 16'h0012, 2, 0);
        add(0, 1, 8'h7A, 1, 6'h03, 0, 0, 16'h0000, 16'h0123, 3, 0);
        add(0, 1, 8'h6B, 1, 6'h04, 0, 0, 16'h0000, 16'h1234, 4, 0);
        add(0, 1, 8'h73, 1, 6'h05, 0, 0, 16'h0000, 16'h1234, 4, 1);
        add(0, 1, 8'h66, 1, 6'h15, 0, 0, 16'h0000, 16'h0123, 3, 0);
        add(0, 1, 8'h76, 1, 6'h16, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 1, 8'h69, 1, 6'h01, 0, 0, 16'h0000, 16'h0001, 1, 0);
        add(0, 1, 8'h72, 1, 6'h02, 0, 0, 16'h0000, 16'h0012, 2, 0);
        add(0, 1, 8'h79, 1, 6'h10, 1, 0, 16'h0012, 16'h0000, 0, 0);
        add(0, 0, 8'h00, 0, 6'h10, 0, 0, 16'h0012, 16'h0000, 0, 0);
        add(0, 1, 8'h7D, 1, 6'h09, 0, 0, 16'h0012, 16'h0009, 1, 0);
        add(0, 1, 8'hE0, 0, 6'h09, 0, 0, 16'h0012, 16'h0009, 1, 0);
`ifdef SCAN_EXT_KEYS_EN
        add(0, 1, 8'h5A, 1, 6'h14, 1, 4, 16'h0009, 16'h0000, 0, 0);
        opc_h = 3'd4; opo_h = 16'h0009;
`else
        add(0, 1, 8'h5A, 1, 6'h30, 0, 0, 16'h0012, 16'h0009, 1, 0);
        opc_h = 3'd0; opo_h = 16'h0012;
`endif
        add(0, 1, 8'h76, 1, 6'h16, 0, opc_h, opo_h, 16'h0000, 0, 0);
        add(0, 1, 8'h70, 1, 6'h00, 0, opc_h, opo_h, 16'h0000, 0, 0);
        add(0, 1, 8'h70, 1, 6'h00, 0, opc_h, opo_h, 16'h0000, 0, 0);
        add(0, 1, 8'h69, 1, 6'h01, 0, opc_h, opo_h, 16'h0001, 1, 0);
        add(0, 1, 8'hE0, 0, 6'h01, 0, opc_h, opo_h, 16'h0001, 1, 0);
        add(1, 0, 8'h00, 0, 6'h00, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 1, 8'h72, 1, 6'h02, 0, 0, 16'h0000, 16'h0002, 1, 0);
        add(0, 1, 8'h11, 1, 6'h30, 0, 0, 16'h0000, 16'h0002, 1, 0);
        add(0, 1, 8'h7B, 1, 6'h11, 1, 1, 16'h0002, 16'h0000, 0, 0);
        add(0, 1, 8'h7C, 1, 6'h12, 1, 2, 16'h0000, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].vld, vecs[i].code);
            check($sformatf("vec%0d_kv", i),  32'(bus.key_valid),   32'(vecs[i].kv));
            check($sformatf("vec%0d_kc", i),  32'(bus.key_code),    32'(vecs[i].kc));
            check($sformatf("vec%0d_opv", i), 32'(bus.op_valid),    32'(vecs[i].opv));
            check($sformatf("vec%0d_opc", i), 32'(bus.op_code),     32'(vecs[i].opc));
            check($sformatf("vec%0d_opo", i), 32'(bus.op_operand),  32'(vecs[i].opo));
            check($sformatf("vec%0d_opr", i), 32'(bus.operand),     32'(vecs[i].opr));
            check($sformatf("vec%0d_cnt", i), 32'(bus.digit_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_ovf", i), 32'(bus.overflow),    32'(vecs[i].ovf));
        end

        // reset asserted on the same edge as a byte strobe: reset wins
        cycle(0, 1, 8'h69);
        cycle(1, 1, 8'h72);
        check("rstwin_kv",  32'(bus.key_valid), 32'd0);
        check("rstwin_opr", 32'(bus.operand),   32'h0);

        // E0 F0 xx is a silent break in both builds
        cycle(0, 1, 8'hE0);
        cycle(0, 1, 8'hF0);
        cycle(0, 1, 8'h69);
        check("e0f0_kv", 32'(bus.key_valid), 32'd0);
        cycle(0, 1, 8'h72);
        check("e0f0_next_kc",  32'(bus.key_code), 32'h02);
        check("e0f0_next_opr", 32'(bus.operand),  32'h0002);

        // idle cycles between E0 and its partner byte keep the prefix
        cycle(0, 1, 8'hE0);
        cycle(0, 0, 8'h4A);
        cycle(0, 0, 8'h4A);
        cycle(0, 1, 8'h4A);
`ifdef SCAN_EXT_KEYS_EN
        check("gap_div_opv", 32'(bus.op_valid),   32'd1);
        check("gap_div_opc", 32'(bus.op_code),    32'd3);
        check("gap_div_opo", 32'(bus.op_operand), 32'h0002);
`else
        check("gap_div_kc",  32'(bus.key_code),   32'h30);
        check("gap_div_opv", 32'(bus.op_valid),   32'd0);
        check("gap_div_opr", 32'(bus.operand),    32'h0002);
`endif

        // random byte stream against the reference model
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                6:       b = 8'hF0;
                7:       b = 8'hE0;
                8:       b = 8'h4A;
                9:       b = 8'h5A;
                10:      b = 8'h66;
                11:      b = 8'h76;
                12:      b = ($urandom_range(0, 2) == 0) ? 8'h79 :
                             ($urandom_range(0, 1) == 0) ? 8'h7B : 8'h7C;
                13:      b = 8'($urandom_range(0, 255));
                default: b = digit_sc[$urandom_range(0, 9)];
            endcase
            cycle(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0), b);
        end

        @(negedge clk);
        bus.scan_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
